// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter onto a single downstream memory port.
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [15:0] if_memaddr,
   input  logic        if_memread,
   input  logic [1:0]  if_mem_byte_enable,
   output logic        if_mem_resp,
   output logic [15:0] if_mem_rdata,

   input  logic [15:0] mem_memaddr,
   input  logic        mem_memread,
   input  logic        mem_memwrite,
   input  logic [15:0] mem_mem_wdata,
   input  logic [1:0]  mem_mem_byte_enable,
   output logic        mem_mem_resp,
   output logic [15:0] mem_mem_rdata,

   output logic [15:0] pmem_address,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [15:0] pmem_wdata,
   output logic [1:0]  pmem_byte_enable,
   input  logic        pmem_resp,
   input  logic [15:0] pmem_rdata
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] SERVE_IF  = 2'd1;
   localparam logic [1:0] SERVE_MEM = 2'd2;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   logic [1:0]  state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  be_q, be_d;
   logic        read_q, read_d;
   logic        write_q, write_d;

   logic mem_req;
   logic grant_if;
   logic grant_mem;

   assign mem_req = mem_memread | mem_memwrite;

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_q, starve_d;
   logic       starve_hit;

   assign starve_hit = (starve_q == 4'(STARVE_LIMIT));
   assign grant_if   = if_memread & (~mem_req | starve_hit);

   // Counts data grants that bypassed a waiting fetch; saturates for safety.
   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE) begin
         if (grant_if)
            starve_d = 4'd0;
         else if (grant_mem && if_memread && starve_q != 4'hF)
            starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) starve_q <= 4'd0;
      else       starve_q <= starve_d;
   end
`else
   assign grant_if = if_memread & ~mem_req;
`endif

   assign grant_mem = mem_req & ~grant_if;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      read_d  = read_q;
      write_d = write_q;
      case (state_q)
         IDLE: begin
            if (grant_mem) begin
               state_d = SERVE_MEM;
               addr_d  = mem_memaddr;
               wdata_d = mem_mem_wdata;
               be_d    = mem_mem_byte_enable;
               // Read+write together is treated as a pure write.
               write_d = mem_memwrite;
               read_d  = ~mem_memwrite;
            end else if (grant_if) begin
               state_d = SERVE_IF;
               addr_d  = if_memaddr;
               wdata_d = 16'h0000;
               be_d    = if_mem_byte_enable;
               write_d = 1'b0;
               read_d  = 1'b1;
            end
         end
         SERVE_IF, SERVE_MEM: begin
            if (pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         be_q    <= 2'b00;
         read_q  <= 1'b0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         read_q  <= read_d;
         write_q <= write_d;
      end
   end

   // Strobes are gated by state so a stale capture never leaks out in IDLE.
   assign pmem_address     = addr_q;
   assign pmem_wdata       = wdata_q;
   assign pmem_byte_enable = be_q;
   assign pmem_read        = (state_q != IDLE) & read_q;
   assign pmem_write       = (state_q != IDLE) & write_q;

   assign if_mem_resp   = (state_q == SERVE_IF)  & pmem_resp;
   assign mem_mem_resp  = (state_q == SERVE_MEM) & pmem_resp;
   assign if_mem_rdata  = pmem_rdata;
   assign mem_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; build with ARB_STARVE_GUARD_EN to cover the guard.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] if_memaddr;
   logic        if_memread;
   logic [1:0]  if_mem_byte_enable;
   logic        if_mem_resp;
   logic [15:0] if_mem_rdata;
   logic [15:0] mem_memaddr;
   logic        mem_memread;
   logic        mem_memwrite;
   logic [15:0] mem_mem_wdata;
   logic [1:0]  mem_mem_byte_enable;
   logic        mem_mem_resp;
   logic [15:0] mem_mem_rdata;
   logic [15:0] pmem_address;
   logic        pmem_read;
   logic        pmem_write;
   logic [15:0] pmem_wdata;
   logic [1:0]  pmem_byte_enable;
   logic        pmem_resp;
   logic [15:0] pmem_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .if_memaddr          (if_memaddr),
      .if_memread          (if_memread),
      .if_mem_byte_enable  (if_mem_byte_enable),
      .if_mem_resp         (if_mem_resp),
      .if_mem_rdata        (if_mem_rdata),
      .mem_memaddr         (mem_memaddr),
      .mem_memread         (mem_memread),
      .mem_memwrite        (mem_memwrite),
      .mem_mem_wdata       (mem_mem_wdata),
      .mem_mem_byte_enable (mem_mem_byte_enable),
      .mem_mem_resp        (mem_mem_resp),
      .mem_mem_rdata       (mem_mem_rdata),
      .pmem_address        (pmem_address),
      .pmem_read           (pmem_read),
      .pmem_write          (pmem_write),
      .pmem_wdata          (pmem_wdata),
      .pmem_byte_enable    (pmem_byte_enable),
      .pmem_resp           (pmem_resp),
      .pmem_rdata          (pmem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock and settle away from the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset               = 1'b1;
      if_memaddr          = 16'h0;
      if_memread          = 1'b0;
      if_mem_byte_enable  = 2'b11;
      mem_memaddr         = 16'h0;
      mem_memread         = 1'b0;
      mem_memwrite        = 1'b0;
      mem_mem_wdata       = 16'h0;
      mem_mem_byte_enable = 2'b11;
      pmem_resp           = 1'b0;
      pmem_rdata          = 16'h0;

      #1;
      chk("rst_pmem_read",  32'(pmem_read),    32'd0);
      chk("rst_pmem_write", 32'(pmem_write),   32'd0);
      chk("rst_pmem_addr",  32'(pmem_address), 32'h0);
      tick(); tick();
      reset = 1'b0;

      // Idle pmem_resp is ignored.
      pmem_resp = 1'b1; #1;
      chk("idle_if_resp",  32'(if_mem_resp),  32'd0);
      chk("idle_mem_resp", 32'(mem_mem_resp), 32'd0);
      pmem_resp = 1'b0;

      // Fetch-only, requester drops mid-service.
      if_memread = 1'b1; if_memaddr = 16'h1000; #1;
      chk("if_req_lat0", 32'(pmem_read), 32'd0);
      tick();
      chk("if_pmem_read",  32'(pmem_read),    32'd1);
      chk("if_pmem_write", 32'(pmem_write),   32'd0);
      chk("if_pmem_addr",  32'(pmem_address), 32'h1000);
      if_memread = 1'b0;
      tick();
      chk("if_wait_resp", 32'(if_mem_resp), 32'd0);
      tick();
      pmem_resp = 1'b1; pmem_rdata = 16'hBEEF; #1;
      chk("if_resp",       32'(if_mem_resp),   32'd1);
      chk("if_rdata",      32'(if_mem_rdata),  32'hBEEF);
      chk("if_other_resp", 32'(mem_mem_resp),  32'd0);
      chk("mem_rdata_pass",32'(mem_mem_rdata), 32'hBEEF);
      tick();
      chk("if_resp_1cyc", 32'(if_mem_resp), 32'd0);
      chk("if_done_idle", 32'(pmem_read),   32'd0);
      pmem_resp = 1'b0;

      // Simultaneous: data (read+write -> write) wins, one idle cycle, then fetch.
      mem_memwrite = 1'b1; mem_memread = 1'b1; mem_memaddr = 16'h2002;
      mem_mem_wdata = 16'h1234; mem_mem_byte_enable = 2'b01;
      if_memread = 1'b1; if_memaddr = 16'h1004; if_mem_byte_enable = 2'b11;
      tick();
      chk("sim_wr",    32'(pmem_write),       32'd1);
      chk("sim_rd",    32'(pmem_read),        32'd0);
      chk("sim_addr",  32'(pmem_address),     32'h2002);
      chk("sim_wdata", 32'(pmem_wdata),       32'h1234);
      chk("sim_be",    32'(pmem_byte_enable), 32'h1);
      pmem_resp = 1'b1; #1;
      chk("sim_mem_resp", 32'(mem_mem_resp), 32'd1);
      chk("sim_if_resp",  32'(if_mem_resp),  32'd0);
      tick();
      pmem_resp = 1'b0; mem_memwrite = 1'b0; mem_memread = 1'b0;
      chk("sim_idle_rd", 32'(pmem_read),  32'd0);
      chk("sim_idle_wr", 32'(pmem_write), 32'd0);
      tick();
      chk("sim_if_rd",   32'(pmem_read),        32'd1);
      chk("sim_if_addr", 32'(pmem_address),     32'h1004);
      chk("sim_if_be",   32'(pmem_byte_enable), 32'h3);
      pmem_resp = 1'b1; #1;
      chk("sim_if_done", 32'(if_mem_resp), 32'd1);
      tick();
      pmem_resp = 1'b0; if_memread = 1'b0;

      // Mid-service address change is not propagated.
      mem_memread = 1'b1; mem_memaddr = 16'h3000; mem_mem_byte_enable = 2'b11;
      tick();
      chk("mid_addr0", 32'(pmem_address), 32'h3000);
      chk("mid_rd",    32'(pmem_read),    32'd1);
      mem_memaddr = 16'h4000;
      tick();
      chk("mid_addr1", 32'(pmem_address), 32'h3000);
      pmem_resp = 1'b1; #1;
      chk("mid_addr2", 32'(pmem_address), 32'h3000);
      chk("mid_resp",  32'(mem_mem_resp), 32'd1);
      tick();
      pmem_resp = 1'b0; mem_memread = 1'b0;
      tick();

      // Reset two cycles into SERVE_IF abandons the transaction.
      if_memread = 1'b1; if_memaddr = 16'h5000;
      tick();
      tick();
      chk("rst_serve_rd", 32'(pmem_read), 32'd1);
      reset = 1'b1; #1;
      chk("rst_async_rd", 32'(pmem_read), 32'd0);
      if_memread = 1'b0;
      tick();
      reset = 1'b0;
      pmem_resp = 1'b1; #1;
      chk("rst_late_resp", 32'(if_mem_resp), 32'd0);
      tick();
      chk("rst_late_resp2", 32'(if_mem_resp), 32'd0);
      chk("rst_stay_idle",  32'(pmem_read),   32'd0);

      // Starvation: both ports request continuously, pmem_resp held high.
      mem_memread = 1'b1; mem_memaddr = 16'h2000;
      if_memread  = 1'b1; if_memaddr  = 16'h1000;
      for (int g = 0; g < 6; g++) begin
         logic [15:0] exp_addr;
`ifdef ARB_STARVE_GUARD_EN
         exp_addr = (g == 4) ? 16'h1000 : 16'h2000;
`else
         exp_addr = 16'h2000;
`endif
         tick();
         chk($sformatf("starve_g%0d", g), 32'(pmem_address), 32'(exp_addr));
         chk($sformatf("starve_r%0d", g), 32'(if_mem_resp), 32'(exp_addr == 16'h1000));
         tick();
      end
      mem_memread = 1'b0; if_memread = 1'b0; pmem_resp = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
